stu_commit_unit: RTL and testbench
==================================

# stu_commit_unit

Speculative Threading Unit commit/rollback controller. Receives speculative tasks from the STU dispatcher in program order. Collects per-core completion and violation reports. Retires tasks strictly in order, squashing the violating task and every younger task. Adapts the speculation level fed back to the dispatcher: demotes on each squash, promotes after a run of clean commits.

## Interface
Parameters:
- NUM_CORES, 4, cores in the cluster; also the queue depth, since each core has at most one outstanding task.
- PROMOTE_THRESH, 16, consecutive clean commits required to raise the level by one.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- alloc_valid  in  1  dispatcher presents a new task.
- alloc_ready  out  1  task accepted when alloc_valid && alloc_ready.
- alloc_core  in  core_id_t  core running the task.
- alloc_pc  in  addr_t  task start PC.
- alloc_level  in  spec_level_t  level the task was dispatched under.
- done_valid  in  NUM_CORES  per-core completion pulse.
- done_violation  in  NUM_CORES  qualifies done_valid; 1 means a dependence violation occurred.
- commit_valid  out  1  one-cycle pulse: the oldest task has retired.
- commit_core  out  core_id_t  core of the retired task.
- commit_pc  out  addr_t  start PC of the retired task.
- squash_valid  out  1  one-cycle pulse: rollback.
- squash_mask  out  NUM_CORES  cores to be squashed; valid only with squash_valid.
- level_override  out  spec_level_t  current maximum level allowed for the dispatcher.
- busy  out  1  queue non-empty.

## Operation
- The order queue is a circular buffer of NUM_CORES entries. Each entry holds core, pc, level, done and viol. Head, tail and count are registered.
- FSM has two states, RUN and SQUASH. Reset enters RUN.
- **Allocation.** alloc_ready = (state==RUN) && (count<NUM_CORES) && rst_n. It does not depend on alloc_core. On acceptance, the entry is written at tail with done=0 and viol=0.
- **Illegal allocation.** Allocating a core that already has an outstanding entry is illegal. The bench asserts this never happens.
- **Completion reports.** done_valid[c] sets done, and sets viol = done_violation[c], on the outstanding entry whose core is c. A report for a core with no outstanding entry is ignored. A report in the same cycle as that core's allocation is ignored.
- **Retirement check.** Each cycle in RUN, the head entry is evaluated as follows:
  - done && !viol: pop the head. Next cycle, commit_valid=1 with the head's core and pc. success_cnt increments.
  - done && viol: flush the whole queue (count=0, head=tail). Next cycle, squash_valid=1, squash_mask = OR of one-hot cores of all entries, state=SQUASH. An entry accepted in this same cycle is included in both the flush and the mask. success_cnt resets to 0.
  - not done: no action. A violation on a younger entry waits until that entry reaches head.
- **SQUASH state.** Lasts exactly one cycle with alloc_ready=0, then returns to RUN. Completion reports arriving during SQUASH are ignored because the queue is empty.
- **Adaptive level.**
  - On squash: level_override decrements by one, saturating at SPEC_LEVEL_0_BYPASS.
  - On commit: if success_cnt reaches PROMOTE_THRESH-1, level_override increments, saturating at SPEC_LEVEL_2_OPTIMISTIC, and success_cnt resets.
  - success_cnt width is $clog2(PROMOTE_THRESH)+1. It saturates while at level 2.
- At most one retirement per cycle. Allocation and retirement can both happen in the same cycle, and count then remains unchanged.

## Timing
- **Reset values:** commit_valid=0, commit_core=0, commit_pc=0, squash_valid=0, squash_mask=0, busy=0, level_override=SPEC_LEVEL_2_OPTIMISTIC, alloc_ready=0 while rst_n=0. Reset asserted mid-operation discards all entries at the next edge with no commit or squash pulse.
- **Completion latency:** done_valid on the head in cycle t leads to commit_valid or squash_valid high in cycle t+2. The report is registered at the end of t, evaluated in t+1, and the output is registered.
- **Back-to-back commits:** possible when consecutive entries are already done.
- **level_override update:** changes in the same cycle as the corresponding commit_valid or squash_valid pulse.
- **Ready behaviour:** alloc_ready drops combinationally when the queue is full and in SQUASH. It rises the cycle after a pop from full.

## Structure
- Add to stu_pkg:
  - a two-state stu_commit_state_t enum;
  - an order-entry struct stu_rob_entry_t (core_id_t, addr_t, spec_level_t, done, viol);
  - a PROMOTE_THRESH default constant.
- One sub-module is natural: stu_level_adapt, containing the success counter and the saturating level up/down logic, driven by commit/squash strobes.

## Test plan
- Allocate core 0 at pc 0x1000 and core 1 at 0x2000. done core1 clean, then core0 clean → commit core0/0x1000, then core1/0x2000 the next cycle. No commit before core0 is done.
- Allocate cores 0–3. done core2 with violation, then core0 and core1 clean → two commits, then squash_mask=4'b1100. level_override drops 2→1. The queue is empty afterwards.
- Fill with 4 tasks → alloc_ready=0. A fifth alloc_valid is held. The first commit raises ready, and the fifth task is accepted the next cycle.
- Head violates while a new alloc (core 3) is accepted in the same cycle → squash_mask includes bit 3. alloc_ready=0 for one cycle, then 1.
- After a demotion to level 1, 16 clean commits → level_override returns to 2 on the 16th commit_valid. A further 16 commits leave it at 2. Three squashes from level 2 saturate at 0.
- Assert rst_n=0 with 3 outstanding entries → busy=0 and no commit or squash pulse. done reports after reset are ignored.

Source files
------------

// File: rtl/stu_pkg.sv
// Shared types for the Speculative Threading Unit: core/address types,
// speculation levels and the commit unit's order-queue entry.
package stu_pkg;

  localparam int STU_NUM_CORES          = 4;
  localparam int PROMOTE_THRESH_DEFAULT = 16;
  localparam int CORE_ID_W              = $clog2(STU_NUM_CORES);

  typedef logic [CORE_ID_W-1:0] core_id_t;
  typedef logic [31:0]          addr_t;

  typedef enum logic [1:0] {
    SPEC_LEVEL_0_BYPASS     = 2'd0,
    SPEC_LEVEL_1_CAUTIOUS   = 2'd1,
    SPEC_LEVEL_2_OPTIMISTIC = 2'd2
  } spec_level_t;

  typedef enum logic {
    STU_COMMIT_RUN    = 1'b0,
    STU_COMMIT_SQUASH = 1'b1
  } stu_commit_state_t;

  typedef struct packed {
    core_id_t    core;
    addr_t       pc;
    spec_level_t level;
    logic        done;
    logic        viol;
  } stu_rob_entry_t;

endpackage

// File: rtl/stu_commit_unit_if.sv
// Dispatcher/core-facing bundle of the commit unit. The master side is the
// dispatcher plus cores; the slave side is the commit unit itself.
interface stu_commit_unit_if
  import stu_pkg::*;
#(
  parameter int NUM_CORES = STU_NUM_CORES
);

  logic                 alloc_valid;
  logic                 alloc_ready;
  core_id_t             alloc_core;
  addr_t                alloc_pc;
  spec_level_t          alloc_level;
  logic [NUM_CORES-1:0] done_valid;
  logic [NUM_CORES-1:0] done_violation;
  logic                 commit_valid;
  core_id_t             commit_core;
  addr_t                commit_pc;
  logic                 squash_valid;
  logic [NUM_CORES-1:0] squash_mask;
  spec_level_t          level_override;
  logic                 busy;

  modport master (
    output alloc_valid, alloc_core, alloc_pc, alloc_level, done_valid, done_violation,
    input  alloc_ready, commit_valid, commit_core, commit_pc, squash_valid, squash_mask,
           level_override, busy
  );

  modport slave (
    input  alloc_valid, alloc_core, alloc_pc, alloc_level, done_valid, done_violation,
    output alloc_ready, commit_valid, commit_core, commit_pc, squash_valid, squash_mask,
           level_override, busy
  );

endinterface

// File: rtl/stu_level_adapt.sv
// Speculation-level governor: demote one step per squash, promote one step
// after PROMOTE_THRESH consecutive clean commits.
module stu_level_adapt
  import stu_pkg::*;
#(
  parameter int PROMOTE_THRESH = PROMOTE_THRESH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_stb,
  input  logic        squash_stb,
  output spec_level_t level
);

  localparam int CNT_W = $clog2(PROMOTE_THRESH) + 1;
  localparam logic [CNT_W-1:0] CNT_PROMOTE = CNT_W'(PROMOTE_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [CNT_W-1:0] success_cnt;

  // At the top level the counter only saturates; a squash restarts the run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level       <= SPEC_LEVEL_2_OPTIMISTIC;
      success_cnt <= '0;
    end else if (squash_stb) begin
      success_cnt <= '0;
      level       <= (level == SPEC_LEVEL_2_OPTIMISTIC) ? SPEC_LEVEL_1_CAUTIOUS
                                                        : SPEC_LEVEL_0_BYPASS;
    end else if (commit_stb) begin
      if (level == SPEC_LEVEL_2_OPTIMISTIC) begin
        if (success_cnt != CNT_MAX) success_cnt <= success_cnt + CNT_W'(1);
      end else if (success_cnt == CNT_PROMOTE) begin
        success_cnt <= '0;
        level       <= (level == SPEC_LEVEL_0_BYPASS) ? SPEC_LEVEL_1_CAUTIOUS
                                                      : SPEC_LEVEL_2_OPTIMISTIC;
      end else begin
        success_cnt <= success_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stu_commit_unit.sv
// In-order commit/rollback controller: tracks speculative tasks in program
// order, retires clean heads and flushes everything on a violating head.
module stu_commit_unit
  import stu_pkg::*;
#(
  parameter int NUM_CORES      = STU_NUM_CORES,
  parameter int PROMOTE_THRESH = PROMOTE_THRESH_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  stu_commit_unit_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [0:0] ST_RUN    = 1'(STU_COMMIT_RUN);
  localparam logic [0:0] ST_SQUASH = 1'(STU_COMMIT_SQUASH);

  stu_rob_entry_t       rob [NUM_CORES];
  logic [0:0]           state;
  logic [PTR_W-1:0]     head, tail, tail_next;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     rel [NUM_CORES];
  logic [NUM_CORES-1:0] entry_live;
  logic [NUM_CORES-1:0] flush_mask;
  logic                 alloc_ready, alloc_fire, head_ready, pop, flush;
  logic                 commit_valid_q, squash_valid_q;
  core_id_t             commit_core_q;
  addr_t                commit_pc_q;
  logic [NUM_CORES-1:0] squash_mask_q;
  spec_level_t          level;
  logic                 unused_level_bits;

  assign alloc_ready = (state == ST_RUN) && (count < CNT_W'(NUM_CORES)) && rst_n;
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign tail_next   = alloc_fire ? tail + PTR_W'(1) : tail;
  assign head_ready  = (state == ST_RUN) && (count != '0) && rob[head].done;
  assign pop         = head_ready && !rob[head].viol;
  assign flush       = head_ready && rob[head].viol;

  // An entry is outstanding when its distance from head is below count.
  always_comb begin
    flush_mask        = '0;
    unused_level_bits = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      rel[i]        = PTR_W'(i) - head;
      entry_live[i] = {1'b0, rel[i]} < count;
      if (entry_live[i]) flush_mask[rob[i].core] = 1'b1;
      unused_level_bits = unused_level_bits ^ (^rob[i].level);
    end
    if (alloc_fire) flush_mask[bus.alloc_core] = 1'b1;
  end

  // A fresh allocation wins over any report for the same slot, so a report
  // arriving alongside its own allocation is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (alloc_fire && tail == PTR_W'(i)) begin
        rob[i] <= '{core: bus.alloc_core, pc: bus.alloc_pc, level: bus.alloc_level,
                    done: 1'b0, viol: 1'b0};
      end else if (entry_live[i] && bus.done_valid[rob[i].core]) begin
        rob[i].done <= 1'b1;
        rob[i].viol <= bus.done_violation[rob[i].core];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit_valid_q <= 1'b0;
      commit_core_q  <= '0;
      commit_pc_q    <= '0;
      squash_valid_q <= 1'b0;
      squash_mask_q  <= '0;
    end else begin
      commit_valid_q <= pop;
      squash_valid_q <= flush;
      squash_mask_q  <= flush ? flush_mask : '0;
      if (pop) begin
        commit_core_q <= rob[head].core;
        commit_pc_q   <= rob[head].pc;
      end
      tail <= tail_next;
      if (flush) begin
        head  <= tail_next;
        count <= '0;
        state <= ST_SQUASH;
      end else begin
        state <= ST_RUN;
        if (pop) head <= head + PTR_W'(1);
        count <= count + CNT_W'(alloc_fire) - CNT_W'(pop);
      end
    end
  end

  stu_level_adapt #(
    .PROMOTE_THRESH(PROMOTE_THRESH)
  ) u_level_adapt (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit_stb(pop),
    .squash_stb(flush),
    .level     (level)
  );

  assign bus.alloc_ready    = alloc_ready;
  assign bus.commit_valid   = commit_valid_q;
  assign bus.commit_core    = commit_core_q;
  assign bus.commit_pc      = commit_pc_q;
  assign bus.squash_valid   = squash_valid_q;
  assign bus.squash_mask    = squash_mask_q;
  assign bus.level_override = level;
  assign bus.busy           = (count != '0);

endmodule

// File: tb/tb_stu_commit_unit.sv
// Self-checking bench for stu_commit_unit: directed scenarios plus random
// traffic, all compared against an in-order queue model of the unit.
module tb_stu_commit_unit;
  import stu_pkg::*;

  localparam int NC = 4;
  localparam int PT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stu_commit_unit_if #(.NUM_CORES(NC)) bus ();

  stu_commit_unit #(
    .NUM_CORES     (NC),
    .PROMOTE_THRESH(PT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          core;
    logic [31:0] pc;
    bit          done;
    bit          viol;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_squash = 1'b0;
  int          m_level = 2;
  int          m_cnt = 0;
  bit          e_cv = 1'b0;
  bit          e_sv = 1'b0;
  logic [3:0]  e_mask = '0;
  int          e_ccore = 0;
  logic [31:0] e_cpc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit outstanding(input int c);
    foreach (mq[i]) if (mq[i].core == c) return 1'b1;
    return 1'b0;
  endfunction

  // Queue model: retire or flush on the head's registered state, then apply
  // reports to surviving entries, then append the accepted task.
  task automatic model_step(input bit fire, input int a_c, input logic [31:0] a_pc,
                            input logic [3:0] dv, input logic [3:0] dvi);
    bit flushed;
    if (!rst_n) begin
      mq.delete();
      m_squash = 1'b0; m_level = 2; m_cnt = 0;
      e_cv = 1'b0; e_sv = 1'b0; e_mask = '0; e_ccore = 0; e_cpc = '0;
      return;
    end
    if (fire && outstanding(a_c)) begin
      failures++;
      $display("[TB] FAIL illegal_alloc core=%0d already outstanding", a_c);
    end
    e_cv = 1'b0; e_sv = 1'b0; e_mask = '0; flushed = 1'b0;
    if (!m_squash && mq.size() > 0 && mq[0].done) begin
      if (!mq[0].viol) begin
        e_cv = 1'b1; e_ccore = mq[0].core; e_cpc = mq[0].pc;
        void'(mq.pop_front());
        if (m_level < 2) begin
          if (m_cnt == PT - 1) begin m_level++; m_cnt = 0; end
          else m_cnt++;
        end
      end else begin
        foreach (mq[i]) e_mask[mq[i].core] = 1'b1;
        if (fire) e_mask[a_c] = 1'b1;
        mq.delete();
        flushed = 1'b1; e_sv = 1'b1;
        if (m_level > 0) m_level--;
        m_cnt = 0;
      end
    end
    foreach (mq[i]) begin
      if (dv[mq[i].core]) begin
        mq[i].done = 1'b1;
        mq[i].viol = dvi[mq[i].core];
      end
    end
    if (fire && !flushed) mq.push_back('{core: a_c, pc: a_pc, done: 1'b0, viol: 1'b0});
    m_squash = e_sv;
  endtask

  task automatic checkOutput();
    check("commit_valid", bus.commit_valid, e_cv);
    check("squash_valid", bus.squash_valid, e_sv);
    check("squash_mask", bus.squash_mask, e_mask);
    check("busy", bus.busy, mq.size() != 0);
    check("level_override", bus.level_override, m_level);
    if (e_cv) begin
      check("commit_core", bus.commit_core, e_ccore);
      check("commit_pc", bus.commit_pc, e_cpc);
    end
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic applyStimulus(input bit av, input int ac, input logic [31:0] apc,
                               input logic [3:0] dv, input logic [3:0] dvi);
    bit exp_ready;
    bus.alloc_valid    = av;
    bus.alloc_core     = core_id_t'(ac);
    bus.alloc_pc       = apc;
    bus.alloc_level    = spec_level_t'($urandom_range(0, 2));
    bus.done_valid     = dv;
    bus.done_violation = dvi;
    #1;
    exp_ready = rst_n && !m_squash && (mq.size() < NC);
    check("alloc_ready", bus.alloc_ready, exp_ready);
    model_step(av && exp_ready, ac, apc, dv, dvi);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 32'h0, 4'b0000, 4'b0000);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] dv, dvi;
    int free_c[$];
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    idle();
    check("rst_commit_valid", bus.commit_valid, 1'b0);
    check("rst_commit_core", bus.commit_core, 0);
    check("rst_commit_pc", bus.commit_pc, 32'h0);
    check("rst_squash_mask", bus.squash_mask, 4'b0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_level", bus.level_override, 2);
    check("rst_ready", bus.alloc_ready, 1'b0);
    rst_n = 1'b1;

    // In-order commit despite out-of-order completion.
    applyStimulus(1'b1, 0, 32'h1000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1, 32'h2000, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 0, 32'h0, 4'b0010, 4'b0000);
    check("s1_no_early_commit", bus.commit_valid, 1'b0);
    applyStimulus(1'b0, 0, 32'h0, 4'b0001, 4'b0000);
    check("s1_latency_not_yet", bus.commit_valid, 1'b0);
    idle();
    check("s1_commit0_valid", bus.commit_valid, 1'b1);
    check("s1_commit0_core", bus.commit_core, 0);
    check("s1_commit0_pc", bus.commit_pc, 32'h1000);
    idle();
    check("s1_commit1_core", bus.commit_core, 1);
    check("s1_commit1_pc", bus.commit_pc, 32'h2000);

    // Younger violation waits for the head, then flushes the rest.
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, c, 32'h3000 + 32'(c) * 32'h10, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 0, 32'h0, 4'b0100, 4'b0100);
    applyStimulus(1'b0, 0, 32'h0, 4'b0011, 4'b0000);
    idle();
    check("s2_commit_a", bus.commit_pc, 32'h3000);
    idle();
    check("s2_commit_b", bus.commit_pc, 32'h3010);
    idle();
    check("s2_squash_valid", bus.squash_valid, 1'b1);
    check("s2_squash_mask", bus.squash_mask, 4'b1100);
    check("s2_level", bus.level_override, 1);
    check("s2_empty", bus.busy, 1'b0);
    check("s2_ready_in_squash", bus.alloc_ready, 1'b0);
    idle();
    check("s2_ready_after", bus.alloc_ready, 1'b1);

    // Full queue holds a fifth request until the first pop.
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, c, 32'h4000 + 32'(c) * 32'h10, 4'b0000, 4'b0000);
    check("s3_full_ready", bus.alloc_ready, 1'b0);
    applyStimulus(1'b1, 0, 32'h5000, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 0, 32'h5000, 4'b0000, 4'b0000);
    check("s3_pop_commit", bus.commit_valid, 1'b1);
    check("s3_ready_rises", bus.alloc_ready, 1'b1);
    applyStimulus(1'b1, 0, 32'h5000, 4'b0000, 4'b0000);
    check("s3_full_again", bus.alloc_ready, 1'b0);
    applyStimulus(1'b0, 0, 32'h0, 4'b1110, 4'b0000);
    idle(); idle(); idle();
    applyStimulus(1'b0, 0, 32'h0, 4'b0001, 4'b0000);
    idle();
    check("s3_fifth_pc", bus.commit_pc, 32'h5000);

    // Violation at head while a new task is accepted in the same cycle.
    applyStimulus(1'b1, 0, 32'h6000, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1, 32'h6100, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 0, 32'h0, 4'b0001, 4'b0001);
    applyStimulus(1'b1, 3, 32'h6300, 4'b0000, 4'b0000);
    check("s4_squash_mask", bus.squash_mask, 4'b1011);
    check("s4_ready_low", bus.alloc_ready, 1'b0);
    idle();
    check("s4_ready_high", bus.alloc_ready, 1'b1);
    check("s4_empty", bus.busy, 1'b0);

    // Promotion: from level 0 (after the s2/s4 demotions) up and saturating.
    check("s5_start_level", bus.level_override, 0);
    for (int i = 0; i < 48; i++) begin
      applyStimulus(1'b1, 0, 32'h7000 + 32'(i), 4'b0000, 4'b0000);
      applyStimulus(1'b0, 0, 32'h0, 4'b0001, 4'b0000);
      idle();
      if (i == 14) check("s5_level_before", bus.level_override, 0);
      if (i == 15) check("s5_level_up1", bus.level_override, 1);
      if (i == 31) check("s5_level_up2", bus.level_override, 2);
      if (i == 47) check("s5_level_sat", bus.level_override, 2);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 0, 32'h8000, 4'b0000, 4'b0000);
      applyStimulus(1'b0, 0, 32'h0, 4'b0001, 4'b0001);
      idle();
      check("s5_demote", bus.level_override, (i == 0) ? 1 : 0);
      idle();
    end

    // Reset with outstanding work: silent discard, later reports ignored.
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, c, 32'h9000 + 32'(c), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 0, 32'h0, 4'b0001, 4'b0000);
    rst_n = 1'b0;
    idle();
    check("s6_busy", bus.busy, 1'b0);
    check("s6_no_commit", bus.commit_valid, 1'b0);
    check("s6_no_squash", bus.squash_valid, 1'b0);
    check("s6_level", bus.level_override, 2);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 32'h0, 4'b0110, 4'b0000);
    idle();
    idle();
    check("s6_still_idle", bus.commit_valid, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      free_c.delete();
      for (int c = 0; c < NC; c++) if (!outstanding(c)) free_c.push_back(c);
      dv = '0;
      dvi = '0;
      for (int c = 0; c < NC; c++) begin
        dv[c]  = ($urandom_range(0, 3) == 0);
        dvi[c] = ($urandom_range(0, 15) == 0);
      end
      if (free_c.size() > 0 && $urandom_range(0, 9) < 6)
        applyStimulus(1'b1, free_c[$urandom_range(0, free_c.size() - 1)], $urandom, dv, dvi);
      else if (free_c.size() == 0)
        applyStimulus(1'b1, $urandom_range(0, NC - 1), $urandom, dv, dvi);
      else
        applyStimulus(1'b0, 0, 32'h0, dv, dvi);
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
